// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the memory arbiter and the byte-wide RAM.
// slave  : arbiter view (takes requests and ram_din; drives done/data/stall and RAM outputs).
// master : requester/environment view (the mirror image of slave).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              if_stall;
  // Load/store requester
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_width;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              mem_stall;
  // Byte-wide RAM port
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_cancel, mem_req, mem_addr, mem_width, mem_wdata, ram_din,
    output if_done, if_inst, if_stall, mem_done, mem_rdata, mem_stall, ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, if_cancel, mem_req, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_done, if_inst, if_stall, mem_done, mem_rdata, mem_stall, ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller sharing one 8-bit RAM port between instruction fetch
// (32-bit reads) and the MEM stage (byte/half/word loads and stores).
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   bus_io - mem_arbiter_if.slave: fetch and load/store handshakes, stalls and RAM port
// MEM requests win over fetch in IDLE. Reads take n+2 cycles from acceptance to done,
// stores n+1. All RAM-side outputs, done pulses and result words are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  mem_arbiter_if.slave    bus_io
);

  typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [2:0]        cnt_nxt;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_nxt;

  assign cnt_nxt  = cnt_q + 3'd1;
  // In a read state, cycle cnt captures the byte addressed in cycle cnt-1.
  assign lane     = 2'(cnt_q - 3'd1);
  assign addr_nxt = base_q + ADDR_W'(cnt_nxt);

  // Transfer length in bytes; unknown codes fall back to a single byte.
  function automatic logic [2:0] len_of(input logic [2:0] w);
    case (w)
      3'b010, 3'b110: len_of = 3'd2;
      3'b100:         len_of = 3'd4;
      default:        len_of = 3'd1;
    endcase
  endfunction

  // Load extension; unknown codes behave as unsigned byte.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] w);
    case (w)
      3'b001:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b010:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = raw;
      3'b110:  extend = {16'h0000, raw[15:0]};
      default: extend = {24'h000000, raw[7:0]};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ram_a_d     = ram_a_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.mem_req) begin
          base_d  = bus_io.mem_addr;
          ram_a_d = bus_io.mem_addr;
          len_d   = len_of(bus_io.mem_width[2:0]);
          width_d = bus_io.mem_width[2:0];
          wdata_d = bus_io.mem_wdata;
          cnt_d   = 3'd0;
          buf_d   = 32'h0;
          if (bus_io.mem_width[3]) begin
            state_d    = StMemWr;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus_io.mem_wdata[7:0];
          end else begin
            state_d = StMemRd;
          end
        end else if (bus_io.if_req && !bus_io.if_cancel) begin
          state_d = StIfRd;
          base_d  = bus_io.if_addr;
          ram_a_d = bus_io.if_addr;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          buf_d   = 32'h0;
        end
      end

      StIfRd, StMemRd: begin
        if (state_q == StIfRd && bus_io.if_cancel) begin
          // Partial bytes stay in buf_q and never reach if_inst.
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            buf_d[{lane, 3'b000} +: 8] = bus_io.ram_din;
          end
          if (cnt_nxt < len_q) begin
            ram_a_d = addr_nxt;
          end
          cnt_d = cnt_nxt;
          if (cnt_q == len_q) begin
            state_d = StDone;
            cnt_d   = 3'd0;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_inst_d = buf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = extend(buf_d, width_q);
            end
          end
        end
      end

      StMemWr: begin
        if (cnt_nxt < len_q) begin
          ram_a_d    = addr_nxt;
          ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_nxt;
        end else begin
          state_d    = StDone;
          mem_done_d = 1'b1;
          cnt_d      = 3'd0;
        end
      end

      StDone: begin
        // Requests are never taken here; the requester drops req this cycle.
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      ram_a_q     <= '0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      width_q     <= 3'd0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ram_a_q     <= ram_a_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_io.ram_a     = ram_a_q;
  assign bus_io.ram_wr    = ram_wr_q;
  assign bus_io.ram_dout  = ram_dout_q;
  assign bus_io.if_done   = if_done_q;
  assign bus_io.if_inst   = if_inst_q;
  assign bus_io.mem_done  = mem_done_q;
  assign bus_io.mem_rdata = mem_rdata_q;
  assign bus_io.if_stall  = bus_io.if_req & ~if_done_q;
  assign bus_io.mem_stall = bus_io.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized fetch/load/store
// traffic compared against a byte-array memory model and arithmetic load extension.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // RAM environment: 512 bytes aliased by the low address bits, one-cycle read latency.
  logic [7:0] env_mem [512];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) env_mem[i] <= 8'($urandom);
      env_mem[9'h100] <= 8'h13;
      env_mem[9'h101] <= 8'h05;
      env_mem[9'h102] <= 8'hA0;
      env_mem[9'h103] <= 8'h00;
      env_mem[9'h020] <= 8'h80;
    end else if (bus.ram_wr) begin
      env_mem[bus.ram_a[8:0]] <= bus.ram_dout;
    end
    bus.ram_din <= env_mem[bus.ram_a[8:0]];
  end

  // Reference model state
  logic [7:0]  model_mem [512];
  logic [31:0] exp_inst;
  logic [31:0] exp_rdata;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] r = 32'h0;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      r = r + (32'(model_mem[a[8:0]]) << (8 * i));
    end
    return r;
  endfunction

  function automatic int width_len(input logic [2:0] w);
    if (w == 3'd2 || w == 3'd6) return 2;
    if (w == 3'd4) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] model_extend(input logic [31:0] raw, input logic [2:0] w);
    if (w == 3'd1 && raw >= 32'd128) return raw + 32'hFFFF_FF00;
    if (w == 3'd2 && raw >= 32'd32768) return raw + 32'hFFFF_0000;
    return raw;
  endfunction

  task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      model_mem[a[8:0]] = 8'(wd >> (8 * i));
    end
  endtask

  task automatic do_mem(input logic [31:0] addr, input logic [3:0] w, input logic [31:0] wd);
    int  n     = width_len(w[2:0]);
    bit  store = w[3];
    int  lat   = store ? n + 1 : n + 2;
    int  k     = 0;
    bit  seen  = 0;
    @(negedge clk);
    check_eq("mem_idle_done", {30'h0, bus.if_done, bus.mem_done}, 32'h0);
    bus.mem_req = 1'b1; bus.mem_addr = addr; bus.mem_width = w; bus.mem_wdata = wd;
    if (store) model_store(addr, n, wd);
    else exp_rdata = model_extend(model_load(addr, n), w[2:0]);
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (k <= n) begin
        check_eq("mem_ram_a", bus.ram_a, addr + 32'(k - 1));
        check_eq("mem_ram_wr", {31'h0, bus.ram_wr}, {31'h0, store});
        if (store) check_eq("mem_ram_dout", {24'h0, bus.ram_dout}, (wd >> (8 * (k - 1))) & 32'hFF);
      end else begin
        check_eq("mem_ram_wr_idle", {31'h0, bus.ram_wr}, 32'h0);
      end
      check_eq("mem_stall", {31'h0, bus.mem_stall}, {31'h0, k != lat});
      if (bus.mem_done) begin
        seen = 1;
        check_eq("mem_latency", k, lat);
        if (!store) check_eq("mem_rdata", bus.mem_rdata, exp_rdata);
      end
    end
    check_eq("mem_done_seen", {31'h0, seen}, 32'h1);
    bus.mem_req = 1'b0;
    check_eq("if_inst_hold", bus.if_inst, exp_inst);
  endtask

  // cancel_idle: raise if_cancel alongside the request for its first cycle only.
  task automatic do_fetch(input logic [31:0] addr, input bit cancel_idle);
    int d   = cancel_idle ? 1 : 0;
    int lat = 6 + d;
    int k   = 0;
    bit seen = 0;
    @(negedge clk);
    check_eq("if_idle_done", {30'h0, bus.if_done, bus.mem_done}, 32'h0);
    bus.if_req = 1'b1; bus.if_addr = addr; bus.if_cancel = cancel_idle;
    exp_inst = model_load(addr, 4);
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      bus.if_cancel = 1'b0;
      if (k > d && k <= 4 + d) check_eq("if_ram_a", bus.ram_a, addr + 32'(k - 1 - d));
      check_eq("if_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
      check_eq("if_stall", {31'h0, bus.if_stall}, {31'h0, k != lat});
      if (bus.if_done) begin
        seen = 1;
        check_eq("if_latency", k, lat);
        check_eq("if_inst", bus.if_inst, exp_inst);
      end
    end
    check_eq("if_done_seen", {31'h0, seen}, 32'h1);
    bus.if_req = 1'b0;
    check_eq("mem_rdata_hold", bus.mem_rdata, exp_rdata);
  endtask

  task automatic do_contention(input logic [31:0] faddr);
    logic [31:0] fetch_val;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = faddr; bus.if_cancel = 1'b0;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h200; bus.mem_width = 4'b0100; bus.mem_wdata = 32'h0;
    exp_rdata = model_load(32'h200, 4);
    fetch_val = model_load(faddr, 4);
    #1;
    check_eq("cont_if_stall_t0", {31'h0, bus.if_stall}, 32'h1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check_eq("cont_mem_done", {31'h0, bus.mem_done}, {31'h0, k == 6});
      check_eq("cont_if_done", {31'h0, bus.if_done}, {31'h0, k == 13});
      check_eq("cont_if_stall", {31'h0, bus.if_stall}, {31'h0, k < 13});
      if (k <= 4) check_eq("cont_mem_ram_a", bus.ram_a, 32'h200 + 32'(k - 1));
      if (k >= 8 && k <= 11) check_eq("cont_if_ram_a", bus.ram_a, faddr + 32'(k - 8));
      if (k == 6) begin
        check_eq("cont_mem_rdata", bus.mem_rdata, exp_rdata);
        bus.mem_req = 1'b0;
      end
      if (k == 13) begin
        exp_inst = fetch_val;
        check_eq("cont_if_inst", bus.if_inst, exp_inst);
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic do_cancel(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] old_inst = exp_inst;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = a; bus.if_cancel = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) check_eq("cancel_ram_a_a", bus.ram_a, a + 32'(k - 1));
      if (k >= 4 && k <= 7) check_eq("cancel_ram_a_b", bus.ram_a, b + 32'(k - 4));
      check_eq("cancel_if_done", {31'h0, bus.if_done}, {31'h0, k == 9});
      if (k <= 8) check_eq("cancel_inst_hold", bus.if_inst, old_inst);
      if (k == 2) bus.if_cancel = 1'b1;
      if (k == 3) begin
        bus.if_cancel = 1'b0;
        bus.if_addr = b;
        exp_inst = model_load(b, 4);
      end
      if (k == 9) begin
        check_eq("cancel_new_inst", bus.if_inst, exp_inst);
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset_in_store();
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_addr = 32'h60; bus.mem_width = 4'b1100;
    bus.mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("rstwr_ram_wr", {31'h0, bus.ram_wr}, 32'h1);
    rst = 1'b1;
    model_store(32'h60, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("rstwr_ram_a", bus.ram_a, 32'h0);
    check_eq("rstwr_ctrl", {29'h0, bus.ram_wr, bus.if_done, bus.mem_done}, 32'h0);
    check_eq("rstwr_dout", {24'h0, bus.ram_dout}, 32'h0);
    check_eq("rstwr_inst", bus.if_inst, 32'h0);
    check_eq("rstwr_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    exp_inst = 32'h0;
    exp_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rstwr_quiet", {30'h0, bus.ram_wr, bus.mem_done}, 32'h0);
    end
  endtask

  initial begin
    int unsigned sel;
    logic [2:0]  wl;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_cancel = 1'b0;
    bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_width = 4'h0; bus.mem_wdata = 32'h0;
    exp_inst = 32'h0;
    exp_rdata = 32'h0;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 512; i++) model_mem[i] = env_mem[i];
    check_eq("reset_ram_a", bus.ram_a, 32'h0);
    check_eq("reset_ctrl", {29'h0, bus.ram_wr, bus.if_done, bus.mem_done}, 32'h0);
    check_eq("reset_dout", {24'h0, bus.ram_dout}, 32'h0);
    check_eq("reset_inst", bus.if_inst, 32'h0);
    check_eq("reset_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;

    do_fetch(32'h100, 1'b0);
    check_eq("fetch_known", bus.if_inst, 32'h00A00513);
    do_mem(32'h20, 4'b0001, 32'h0);
    check_eq("lb_known", bus.mem_rdata, 32'hFFFF_FF80);
    do_mem(32'h20, 4'b0101, 32'h0);
    check_eq("lbu_known", bus.mem_rdata, 32'h0000_0080);
    do_mem(32'h40, 4'b1010, 32'h1234_ABCD);
    do_mem(32'h40, 4'b0100, 32'h0);
    do_mem(32'hFFFF_FFFE, 4'b0100, 32'h0);
    do_mem(32'h21, 4'b0011, 32'h0);
    do_fetch(32'h104, 1'b1);
    do_contention(32'h100);
    do_cancel(32'h180, 32'h100);
    do_reset_in_store();
    do_fetch(32'h64, 1'b0);

    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        do_fetch($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 3) == 0));
      end else if (sel == 1) begin
        wl = 3'($urandom_range(0, 7));
        do_mem($urandom, {1'b0, wl}, 32'h0);
      end else begin
        wl = 3'($urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) == 0 ? 2 : 4));
        do_mem($urandom, {1'b1, wl}, $urandom);
      end
    end

    @(negedge clk);
    for (int i = 0; i < 512; i++) check_eq("ram_image", {24'h0, env_mem[i]}, {24'h0, model_mem[i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory controller that shares the single 8-bit RAM port between the instruction-fetch stage (32-bit instruction reads) and the MEM stage (loads and stores with the decoder's 4-bit width code). It sequences the multi-cycle byte transfers, assembles and sign- or zero-extends load data, and raises per-requester stall signals while a transfer is pending. It also accepts a fetch-cancel from the branch/flush logic.

## Interface
- `ADDR_W`, 32: address width of requests and RAM.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; level, held until `if_done` or cancel.
- `if_addr` in ADDR_W: fetch byte address (word-aligned).
- `if_cancel` in 1: abort pending/in-flight fetch (mispredict/flush).
- `if_done` out 1: one-cycle pulse, `if_inst` valid.
- `if_inst` out 32: assembled instruction, little-endian.
- `mem_req` in 1: load/store request; level, held until `mem_done`.
- `mem_addr` in ADDR_W: load/store byte address.
- `mem_width` in 4: bit3 = store. Low 3 bits: 001 byte, 010 half, 100 word, 101 byte-unsigned, 110 half-unsigned (loads only).
- `mem_wdata` in 32: store data, little-endian.
- `mem_done` out 1: one-cycle pulse; for loads `mem_rdata` valid.
- `mem_rdata` out 32: extended load result.
- `if_stall` out 1: `if_req` & ~`if_done`.
- `mem_stall` out 1: `mem_req` & ~`mem_done`.
- `ram_a` out ADDR_W: RAM byte address.
- `ram_wr` out 1: 1 = write `ram_dout` at `ram_a` this cycle.
- `ram_dout` out 8: write byte.
- `ram_din` in 8: read byte, valid one cycle after its address.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE: `mem_req` has priority over `if_req`. A request is accepted at the edge; the controller latches the base address, length n (1/2/4), kind, width and wdata, and sets the byte counter i=0.
- IF_RD / MEM_RD:
  - Cycle i drives `ram_a`=base+i for i<n.
  - Byte i is captured from `ram_din` one cycle later into lane i.
  - After byte n-1 is captured, go to DONE.
- MEM_WR: cycle i drives `ram_a`=base+i, `ram_dout`=wdata[8i+7:8i], `ram_wr`=1. After i=n-1, go to DONE.
- DONE:
  - Pulse the matching done for one cycle.
  - Load result: bytes zero-filled above n. Width codes 001/010 sign-extend from bit 7/15; 101/110 zero-extend.
  - Return to IDLE. A request is never accepted in DONE; the requester deasserts req in the done cycle.
- `if_cancel`:
  - In IDLE it suppresses acceptance of `if_req` that cycle.
  - In IF_RD it returns to IDLE at the next edge with no `if_done`. Discarded bytes do not reach `if_inst`.
  - It has no effect on MEM_RD/MEM_WR or on a MEM transfer's DONE.
- Invalid `mem_width` low bits (000, 011, 111): treated as byte, unsigned; completes normally.
- Address arithmetic is ADDR_W-bit modulo; base+i wraps at 2^ADDR_W.
- Reset mid-transfer: abandons it. Any store bytes already written remain; no done is issued.
- `ram_wr` is high only in MEM_WR.

## Timing
- Reset values:
  - state IDLE.
  - `if_done`, `mem_done`, `ram_wr` = 0.
  - `ram_a`, `ram_dout`, `if_inst`, `mem_rdata` = 0.
  - counters = 0.
- `if_stall`/`mem_stall` are combinational from req and done.
- All RAM-side outputs are registered.
- With request sampled high in IDLE in cycle t:
  - `ram_a`=base in t+1.
  - Read of n bytes: done in cycle t+n+2.
  - Store of n bytes: writes in t+1..t+n, done in t+n+1.
- Word fetch: 6 cycles from request to `if_done`; next request accepted earliest at t+7.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM served first. IF is accepted in the first IDLE cycle after MEM's DONE.
- `if_inst`/`mem_rdata` hold their value until the next completion of the same requester.

## Test plan
- Fetch: RAM[0x100..0x103]=13,05,A0,00, `if_req` addr 0x100 at t → `ram_a` 0x100..0x103 in t+1..t+4; `if_done` at t+6 with `if_inst`=0x00A00513.
- LB vs LBU: RAM[0x20]=0x80 → width 0001 gives `mem_rdata`=0xFFFFFF80; width 0101 gives 0x00000080; `mem_done` at t+3.
- SH: addr 0x40, wdata 0x1234ABCD, width 1010 → `ram_wr` at t+1 (0x40←CD) and t+2 (0x41←AB); `mem_done` t+3; RAM[0x42] untouched.
- Contention: `if_req` and `mem_req` (LW 0x200) both rise at t → LW completes at t+6; fetch starts with `ram_a` at t+8 and `if_done` at t+13; `if_stall` high throughout t..t+12.
- Cancel: `if_cancel` pulsed at t+2 of a fetch → IDLE at t+3, no `if_done`, `if_inst` unchanged; new fetch accepted at t+3.
- Reset during MEM_WR after one byte written → all outputs zero next cycle, no `mem_done`, state IDLE.
